// File: rtl/blend_pack_writer.sv
// rtl/blend_pack_writer.sv - blends two RGB565 pixel streams, packs pixel pairs into 32-bit words
// and queues them as write requests to frame memory.
module blend_pack_writer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_25,
    input  logic        rst_n,
    input  logic        val,
    input  logic [9:0]  sync_x,
    input  logic [9:0]  sync_y,
    input  logic [4:0]  dvi_r,
    input  logic [5:0]  dvi_g,
    input  logic [4:0]  dvi_b,
    input  logic [4:0]  ccd_r,
    input  logic [5:0]  ccd_g,
    input  logic [4:0]  ccd_b,
    input  logic [1:0]  mode,
    output logic        wr_req,
    output logic [17:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_ack,
    output logic        overflow,
    output logic        seq_err,
    output logic        frame_done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [17:0] LAST_ADDR = 18'(H_ACTIVE * V_ACTIVE / 2 - 1);

    typedef enum logic {IDLE, REQ} state_t;

    // 5-bit channels are zero-extended, so the 6-bit result truncates cleanly back to 5 bits.
    function automatic logic [5:0] blend_ch(input logic [1:0] m, input logic [5:0] a,
                                            input logic [5:0] b);
        logic [6:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (m)
            2'b00:   return a;
            2'b01:   return b;
            2'b10:   return sum[6:1];
            default: return (a >= b) ? (a - b) : (b - a);
        endcase
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [15:0] mix;
    logic [17:0] pix_addr;

    assign mix = {5'(blend_ch(mode, {1'b0, dvi_r}, {1'b0, ccd_r})),
                  blend_ch(mode, dvi_g, ccd_g),
                  5'(blend_ch(mode, {1'b0, dvi_b}, {1'b0, ccd_b}))};
    assign pix_addr = 18'((20'(sync_y) * 20'(H_ACTIVE) + 20'(sync_x)) >> 1);

    logic        s1_valid, s1_odd;
    logic [15:0] s1_pix;
    logic [17:0] s1_addr;

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_odd   <= 1'b0;
            s1_pix   <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= val;
            if (val) begin
                s1_odd  <= sync_x[0];
                s1_pix  <= mix;
                s1_addr <= pix_addr;
            end
        end
    end

    logic        pend_valid;
    logic [15:0] pend_pix;
    logic [17:0] pend_addr;
    logic        push, pend_load, pend_clr, seq_hit;
    logic [49:0] push_entry;

    // An unmatched pending even pixel is always flushed as a half word rather than lost.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        pend_load  = 1'b0;
        pend_clr   = 1'b0;
        seq_hit    = 1'b0;
        if (s1_valid) begin
            if (!s1_odd) begin
                pend_load = 1'b1;
                if (pend_valid) begin
                    push       = 1'b1;
                    push_entry = {pend_addr, 16'h0000, pend_pix};
                    seq_hit    = 1'b1;
                end
            end else if (pend_valid && (pend_addr == s1_addr)) begin
                push       = 1'b1;
                push_entry = {pend_addr, s1_pix, pend_pix};
                pend_clr   = 1'b1;
            end else begin
                seq_hit = 1'b1;
                if (pend_valid) begin
                    push       = 1'b1;
                    push_entry = {pend_addr, 16'h0000, pend_pix};
                    pend_clr   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_pix   <= '0;
            pend_addr  <= '0;
        end else if (pend_load) begin
            pend_valid <= 1'b1;
            pend_pix   <= s1_pix;
            pend_addr  <= s1_addr;
        end else if (pend_clr) begin
            pend_valid <= 1'b0;
        end
    end

    logic [49:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] count;
    logic          full, empty, pop, do_push;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign rd_nxt  = ptr_inc(rd_ptr);
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk_25) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= rd_nxt;
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    state_t      state, state_nxt;
    logic        load;
    logic [49:0] head_sel;

    always_ff @(posedge clk_25) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        head_sel  = mem[rd_ptr];
        case (state)
            IDLE: begin
                if (!empty) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (wr_ack) begin
                    pop = 1'b1;
                    if (count > CW'(1)) begin
                        load     = 1'b1;
                        head_sel = mem[rd_nxt];
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            overflow   <= 1'b0;
            seq_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_req <= (state_nxt == REQ);
            if (load) begin
                wr_addr <= head_sel[49:32];
                wr_data <= head_sel[31:0];
            end
            overflow   <= overflow | (push && full && !pop);
            seq_err    <= seq_err | seq_hit;
            frame_done <= (state == REQ) && wr_ack && (wr_addr == LAST_ADDR);
        end
    end

endmodule

// File: tb/tb_blend_pack_writer.sv
// tb/tb_blend_pack_writer.sv - directed vector bench for blend_pack_writer
module tb_blend_pack_writer;

    localparam int H = 640;
    localparam int V = 8;
    localparam int WORDS = H * V / 2;
    localparam logic [17:0] LAST = 18'(WORDS - 1);

    logic        clk_25 = 1'b0;
    logic        rst_n = 1'b0;
    logic        val = 1'b0;
    logic [9:0]  sync_x = '0, sync_y = '0;
    logic [4:0]  dvi_r = '0, dvi_b = '0, ccd_r = '0, ccd_b = '0;
    logic [5:0]  dvi_g = '0, ccd_g = '0;
    logic [1:0]  mode = '0;
    logic        wr_ack = 1'b0;
    logic        wr_req, overflow, seq_err, frame_done;
    logic [17:0] wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    logic [49:0] got_q[$];
    int          fd_cnt = 0;
    logic        fd_ok = 1'b0;
    logic        fd_last_seen = 1'b0;

    blend_pack_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(8)) dut (
        .clk_25(clk_25), .rst_n(rst_n), .val(val), .sync_x(sync_x), .sync_y(sync_y),
        .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
        .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b), .mode(mode),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .overflow(overflow), .seq_err(seq_err), .frame_done(frame_done)
    );

    always #20 clk_25 = ~clk_25;

    always @(negedge clk_25) begin
        if (fd_last_seen) fd_ok = frame_done;
        fd_last_seen = rst_n && wr_req && wr_ack && (wr_addr == LAST);
        if (frame_done) fd_cnt = fd_cnt + 1;
        if (rst_n && wr_req && wr_ack) got_q.push_back({wr_addr, wr_data});
    end

    typedef struct {
        logic [1:0]  m;
        logic [15:0] d0, c0, d1, c1;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_25);
        #1;
    endtask

    task automatic do_reset();
        wr_ack = 1'b0;
        val    = 1'b0;
        @(posedge clk_25); #1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        got_q.delete();
    endtask

    task automatic send(input int x, input int y, input logic [15:0] d, input logic [15:0] c,
                        input logic [1:0] m);
        val    = 1'b1;
        sync_x = 10'(x);
        sync_y = 10'(y);
        {dvi_r, dvi_g, dvi_b} = d;
        {ccd_r, ccd_g, ccd_b} = c;
        mode   = m;
        @(posedge clk_25); #1;
        val = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [17:0] a, input logic [31:0] d);
        logic [49:0] e;
        e = '1;
        chk({name, "_present"}, 64'(got_q.size() > 0), 64'd1);
        if (got_q.size() > 0) e = got_q.pop_front();
        chk({name, "_word"}, 64'(e), 64'({a, d}));
    endtask

    vec_t vecs[6];
    int   waited;

    initial begin
        vecs[0] = '{2'b10, 16'hFFFF, 16'h0821, 16'h0821, 16'h0821, 32'h08218410};
        vecs[1] = '{2'b11, 16'hFFFF, 16'h0821, 16'h0821, 16'hFFFF, 32'hF7DEF7DE};
        vecs[2] = '{2'b01, 16'h1234, 16'h5678, 16'hAAAA, 16'h9ABC, 32'h9ABC5678};
        vecs[3] = '{2'b00, 16'hCAFE, 16'h0000, 16'hBEEF, 16'h0000, 32'hBEEFCAFE};
        vecs[4] = '{2'b10, 16'h18A7, 16'h0000, 16'h0000, 16'h18A7, 32'h08430843};
        vecs[5] = '{2'b11, 16'h0000, 16'h18A7, 16'h18A7, 16'h0843, 32'h106418A7};

        do_reset();
        chk("rst_wr_req", 64'(wr_req), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_seq_err", 64'(seq_err), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);

        // first word: latency from the odd pixel's strobe to wr_req
        send(0, 0, 16'h1234, 16'h0000, 2'b00);
        send(1, 0, 16'hABCD, 16'h0000, 2'b00);
        chk("lat_c1", 64'(wr_req), 64'd0);
        tick(1);
        chk("lat_c2", 64'(wr_req), 64'd0);
        tick(1);
        chk("lat_c3", 64'(wr_req), 64'd1);
        chk("lat_addr", 64'(wr_addr), 64'd0);
        chk("lat_data", 64'(wr_data), 64'hABCD1234);
        wr_ack = 1'b1;
        tick(1);
        wr_ack = 1'b0;
        chk("lat_req_drop", 64'(wr_req), 64'd0);
        got_q.delete();

        wr_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(2 * i, 0, vecs[i].d0, vecs[i].c0, vecs[i].m);
            send(2 * i + 1, 0, vecs[i].d1, vecs[i].c1, vecs[i].m);
            tick(5);
            expect_word($sformatf("vec%0d", i), 18'(i), vecs[i].exp);
            chk($sformatf("vec%0d_extra", i), 64'(got_q.size()), 64'd0);
        end
        chk("vec_seq_err", 64'(seq_err), 64'd0);
        chk("vec_overflow", 64'(overflow), 64'd0);

        // orphan odd pixel with nothing pending
        do_reset();
        wr_ack = 1'b1;
        send(9, 0, 16'h5555, 16'h0000, 2'b00);
        tick(5);
        chk("orphan_seq_err", 64'(seq_err), 64'd1);
        chk("orphan_no_word", 64'(got_q.size()), 64'd0);

        // two even pixels in a row
        do_reset();
        wr_ack = 1'b1;
        send(4, 0, 16'h1111, 16'h0000, 2'b00);
        send(6, 0, 16'h2222, 16'h0000, 2'b00);
        tick(5);
        expect_word("even_even", 18'd2, 32'h00001111);
        chk("even_even_seq_err", 64'(seq_err), 64'd1);
        send(7, 0, 16'h3333, 16'h0000, 2'b00);
        tick(5);
        expect_word("even_even_repair", 18'd3, 32'h33332222);
        chk("even_even_extra", 64'(got_q.size()), 64'd0);

        // FIFO fill with memory stalled
        do_reset();
        for (int k = 0; k < 9; k++) begin
            send(2 * k, 0, 16'(2 * k), 16'h0000, 2'b00);
            send(2 * k + 1, 0, 16'(2 * k + 1), 16'h0000, 2'b00);
        end
        tick(5);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_req", 64'(wr_req), 64'd1);
        chk("ovf_addr", 64'(wr_addr), 64'd0);
        chk("ovf_data", 64'(wr_data), 64'h00010000);
        tick(4);
        chk("ovf_addr_hold", 64'(wr_addr), 64'd0);
        chk("ovf_data_hold", 64'(wr_data), 64'h00010000);
        chk("ovf_req_hold", 64'(wr_req), 64'd1);
        wr_ack = 1'b1;
        tick(20);
        chk("ovf_drained", 64'(got_q.size()), 64'd8);
        for (int j = 0; j < 8; j++)
            expect_word($sformatf("ovf_w%0d", j), 18'(j), {16'(2 * j + 1), 16'(2 * j)});
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // reset in the middle of a handshake
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send(2 * k, 0, 16'hA000, 16'h0000, 2'b00);
            send(2 * k + 1, 0, 16'hB000, 16'h0000, 2'b00);
        end
        waited = 0;
        while (!wr_req && waited < 20) begin
            tick(1);
            waited++;
        end
        chk("mid_req_up", 64'(wr_req), 64'd1);
        rst_n = 1'b0;
        tick(1);
        chk("mid_req_drop", 64'(wr_req), 64'd0);
        rst_n = 1'b1;
        wr_ack = 1'b1;
        got_q.delete();
        tick(20);
        chk("mid_no_writes", 64'(got_q.size()), 64'd0);
        chk("mid_req_idle", 64'(wr_req), 64'd0);

        // whole frame with memory always ready
        do_reset();
        wr_ack = 1'b1;
        fd_cnt = 0;
        fd_ok  = 1'b0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                send(x, y, 16'(y * H + x), 16'h0000, 2'b00);
        tick(20);
        chk("frame_count", 64'(got_q.size()), 64'(WORDS));
        for (int i = 0; i < WORDS; i++)
            expect_word($sformatf("frame_w%0d", i), 18'(i), {16'(2 * i + 1), 16'(2 * i)});
        chk("frame_done_pulses", 64'(fd_cnt), 64'd1);
        chk("frame_done_after_last", 64'(fd_ok), 64'd1);
        chk("frame_seq_err", 64'(seq_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
